// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: load handshake bundle carrying one pattern word into the transmitter
interface seq_pattern_tx_if #(parameter int WIDTH = 4);
  logic load_valid;
  logic load_ready;
  logic [WIDTH-1:0] load_data;
  modport master(output load_valid, load_data, input load_ready);
  modport slave(input load_valid, load_data, output load_ready);
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern transmitter with post-frame gap; SEQ_TX_LOOP_EN adds the loop input for continuous repeat
module seq_pattern_tx #(
  parameter int WIDTH = 4,
  parameter int GAP = 1
) (
  input logic clk,
  input logic rst,
  seq_pattern_tx_if.slave ld,
  output logic x,
  output logic x_valid,
  output logic busy,
  output logic done
`ifdef SEQ_TX_LOOP_EN
  ,
  input logic loop
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP == 0 ? 0 : GAP - 1);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [WIDTH-1:0] sr, sr_n, sw;
  logic x_n, xv_n, busy_n, done_n, ready_n, start;
`ifdef SEQ_TX_LOOP_EN
  logic [WIDTH-1:0] word;
  logic rep, rep_n;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt <= '0;
      gcnt <= '0;
      sr <= '0;
      x <= 1'b0;
      x_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      ld.load_ready <= 1'b1;
`ifdef SEQ_TX_LOOP_EN
      word <= '0;
      rep <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      gcnt <= gcnt_n;
      sr <= sr_n;
      x <= x_n;
      x_valid <= xv_n;
      busy <= busy_n;
      done <= done_n;
      ld.load_ready <= ready_n;
`ifdef SEQ_TX_LOOP_EN
      rep <= rep_n;
      if (start) word <= sw;
`endif
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    gcnt_n = gcnt;
    sr_n = sr;
    x_n = 1'b0;
    xv_n = 1'b0;
    busy_n = 1'b0;
    done_n = 1'b0;
    ready_n = 1'b0;
    start = 1'b0;
    sw = ld.load_data;
`ifdef SEQ_TX_LOOP_EN
    rep_n = rep;
`endif
    case (state)
      S_IDLE: begin
        ready_n = 1'b1;
        start = ld.load_valid;
      end
      S_SHIFT: begin
        if (cnt == CLAST) begin
          done_n = 1'b1;
          if (GAP == 0) begin
            state_n = S_IDLE;
            ready_n = 1'b1;
          end else begin
            state_n = S_GAP;
            gcnt_n = '0;
            busy_n = 1'b1;
          end
`ifdef SEQ_TX_LOOP_EN
          rep_n = loop;
          if (loop && GAP == 0) begin
            start = 1'b1;
            sw = word;
          end
`endif
        end else begin
          cnt_n = cnt + CW'(1);
          sr_n = sr << 1;
          x_n = sr[WIDTH-2];
          xv_n = 1'b1;
          busy_n = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt == GLAST) begin
          state_n = S_IDLE;
          ready_n = 1'b1;
`ifdef SEQ_TX_LOOP_EN
          if (rep) begin
            start = 1'b1;
            sw = word;
          end
`endif
        end else begin
          gcnt_n = gcnt + GW'(1);
          busy_n = 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        ready_n = 1'b1;
      end
    endcase
    // a new frame (fresh load or loop repeat) overrides the exit decision above
    if (start) begin
      state_n = S_SHIFT;
      sr_n = sw;
      cnt_n = '0;
      x_n = sw[WIDTH-1];
      xv_n = 1'b1;
      busy_n = 1'b1;
      ready_n = 1'b0;
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed checks of framing, gap, handshake, reset abort and (optionally) loop mode
module tb_seq_pattern_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic x0, xv0, busy0, done0, x1, xv1, busy1, done1;
  logic loop0 = 1'b0;
  logic loop1 = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  seq_pattern_tx_if #(.WIDTH(4)) a ();
  seq_pattern_tx_if #(.WIDTH(2)) b ();
  seq_pattern_tx #(.WIDTH(4), .GAP(1)) d0 (
    .clk(clk), .rst(rst), .ld(a), .x(x0), .x_valid(xv0), .busy(busy0), .done(done0)
`ifdef SEQ_TX_LOOP_EN
    , .loop(loop0)
`endif
  );
  seq_pattern_tx #(.WIDTH(2), .GAP(0)) d1 (
    .clk(clk), .rst(rst), .ld(b), .x(x1), .x_valid(xv1), .busy(busy1), .done(done1)
`ifdef SEQ_TX_LOOP_EN
    , .loop(loop1)
`endif
  );
  always #5 clk = ~clk;
  wire [4:0] o0 = {x0, xv0, done0, busy0, a.load_ready};
  wire [4:0] o1 = {x1, xv1, done1, busy1, b.load_ready};
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  // one WIDTH=4/GAP=1 frame; o0 = {x, x_valid, done, busy, load_ready}
  task automatic frame0(input string tag, input logic [3:0] w, input logic hold, input logic [3:0] nd);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) begin
        a.load_valid = hold;
        a.load_data = nd;
      end
      chk($sformatf("%s_bit%0d", tag, k), 8'(o0), 8'({w[3-k], 4'b1010}));
    end
    step();
    chk({tag, "_done"}, 8'(o0), 8'b00110);
    step();
    chk({tag, "_idle"}, 8'(o0), 8'b00001);
  endtask
  initial begin
    a.load_valid = 1'b0;
    a.load_data = '0;
    b.load_valid = 1'b0;
    b.load_data = '0;
    step();
    step();
    chk("rst0", 8'(o0), 8'b00001);
    chk("rst1", 8'(o1), 8'b00001);
    rst = 1'b1;
    step();
    chk("idle", 8'(o0), 8'b00001);
    a.load_valid = 1'b1;
    a.load_data = 4'b1010;
    frame0("basic", 4'b1010, 1'b0, 4'b1010);
    a.load_valid = 1'b1;
    a.load_data = 4'b1111;
    frame0("hold1", 4'b1111, 1'b1, 4'b0001);
    frame0("hold2", 4'b0001, 1'b0, 4'b0001);
    a.load_valid = 1'b1;
    a.load_data = 4'b1100;
    frame0("chg", 4'b1100, 1'b0, 4'b0011);
    a.load_valid = 1'b1;
    a.load_data = 4'b1011;
    step();
    a.load_valid = 1'b0;
    chk("abort_b0", 8'(o0), 8'b11010);
    step();
    chk("abort_b1", 8'(o0), 8'b01010);
    #2 rst = 1'b0;
    #1 chk("abort_async", 8'(o0), 8'b00001);
    step();
    step();
    chk("abort_nodone", 8'(o0), 8'b00001);
    rst = 1'b1;
    step();
    chk("abort_idle", 8'(o0), 8'b00001);
    a.load_valid = 1'b1;
    a.load_data = 4'b0110;
    frame0("after", 4'b0110, 1'b0, 4'b0110);
    b.load_valid = 1'b1;
    b.load_data = 2'b01;
    step();
    b.load_data = 2'b10;
    chk("g0_b0", 8'(o1), 8'b01010);
    step();
    chk("g0_b1", 8'(o1), 8'b11010);
    step();
    chk("g0_done", 8'(o1), 8'b00101);
    step();
    b.load_valid = 1'b0;
    chk("g0_next_b0", 8'(o1), 8'b11010);
    step();
    chk("g0_next_b1", 8'(o1), 8'b01010);
    step();
    chk("g0_next_done", 8'(o1), 8'b00101);
    step();
    chk("g0_idle", 8'(o1), 8'b00001);
`ifdef SEQ_TX_LOOP_EN
    loop0 = 1'b1;
    a.load_valid = 1'b1;
    a.load_data = 4'b1010;
    for (int k = 0; k < 11; k++) begin
      logic [4:0] e;
      logic [3:0] w;
      w = 4'b1010;
      step();
      if (k == 0) a.load_valid = 1'b0;
      if (k == 5) loop0 = 1'b0;
      e = k < 4 ? {w[3-k], 4'b1010} : k == 4 ? 5'b00110 : k < 9 ? {w[8-k], 4'b1010} : k == 9 ? 5'b00110 : 5'b00001;
      chk($sformatf("loop_c%0d", k), 8'(o0), 8'(e));
    end
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
